// File: rtl/stg1if_pbuf_pkg.sv
// Shared sizes and helpers for the fetch-to-decode prefetch buffer.
// Provides SIZE_DATA/SIZE_ADDR/HBIT_* (sizes.vh content) and a depth check.
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef HBIT_DATA
`define HBIT_DATA (`SIZE_DATA - 1)
`endif
`ifndef HBIT_ADDR
`define HBIT_ADDR (`SIZE_ADDR - 1)
`endif

package stg1if_pbuf_pkg;
    localparam int SIZE_DATA = `SIZE_DATA;
    localparam int SIZE_ADDR = `SIZE_ADDR;
    localparam int HBIT_DATA = `HBIT_DATA;
    localparam int HBIT_ADDR = `HBIT_ADDR;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction
endpackage

// File: rtl/stg1if_pbuf_if.sv
// Fetch/decode handshake bundle around the prefetch buffer.
// master: fetch+decode side (drives words, stall, flush); slave: buffer.
interface stg1if_pbuf_if
    import stg1if_pbuf_pkg::*;
#(
    parameter int P_DATA_W = SIZE_DATA,
    parameter int P_ADDR_W = SIZE_ADDR,
    parameter int P_DEPTH  = 4
);
    localparam int CW = $clog2(P_DEPTH + 1);

    logic                iw_ia_valid;
    logic [P_ADDR_W-1:0] iw_pc;
    logic [P_DATA_W-1:0] iw_mem_data;
    logic                iw_stall;
    logic                iw_flush;
    logic                ow_ready;
    logic                ow_valid;
    logic [P_ADDR_W-1:0] ow_pc;
    logic [P_DATA_W-1:0] ow_instr;
    logic [CW-1:0]       ow_count;
    logic                ow_ovf;

    modport master (
        output iw_ia_valid, iw_pc, iw_mem_data,
        output iw_stall, iw_flush,
        input  ow_ready, ow_valid, ow_pc, ow_instr,
        input  ow_count, ow_ovf
    );

    modport slave (
        input  iw_ia_valid, iw_pc, iw_mem_data,
        input  iw_stall, iw_flush,
        output ow_ready, ow_valid, ow_pc, ow_instr,
        output ow_count, ow_ovf
    );
endinterface

// File: rtl/stg1if_pbuf_mem.sv
// Prefetch entry storage: P_DEPTH x P_W register array.
// Ports: one write port (we/waddr/wdata), asynchronous read (raddr/rdata).
module stg1if_pbuf_mem #(
    parameter int P_DEPTH = 4,
    parameter int P_W     = 64
) (
    input  logic                       iw_clk,
    input  logic                       iw_rst,
    input  logic                       iw_we,
    input  logic [$clog2(P_DEPTH)-1:0] iw_waddr,
    input  logic [P_W-1:0]             iw_wdata,
    input  logic [$clog2(P_DEPTH)-1:0] iw_raddr,
    output logic [P_W-1:0]             ow_rdata
);
    logic [P_W-1:0] mem_q [P_DEPTH];
    logic [P_W-1:0] mem_d [P_DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (iw_we) begin
            mem_d[iw_waddr] = iw_wdata;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign ow_rdata = mem_q[iw_raddr];
endmodule

// File: rtl/stg1if_pbuf.sv
// Prefetch FIFO between fetch and decode; pointers, count, overflow flag.
// Ports: iw_clk, iw_rst (async, active-high), bus (slave side of bundle).
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

module stg1if_pbuf
    import stg1if_pbuf_pkg::*;
#(
    parameter int P_DATA_W = `SIZE_DATA,
    parameter int P_ADDR_W = `SIZE_ADDR,
    parameter int P_DEPTH  = 4
) (
    input  logic           iw_clk,
    input  logic           iw_rst,
    stg1if_pbuf_if.slave   bus
);
    localparam int AW = $clog2(P_DEPTH);
    localparam int CW = $clog2(P_DEPTH + 1);
    localparam int EW = P_ADDR_W + P_DATA_W;

    if (!is_pow2(P_DEPTH)) begin : g_depth_chk
        $error("P_DEPTH must be a power of 2 and >= 2");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          ready, valid, enq, deq;
    logic [EW-1:0] head;

    // Ready looks only at the registered count, so a full buffer
    // refuses a word even when decode drains one on the same edge.
    assign ready = (count_q < CW'(P_DEPTH));
    assign valid = (count_q != '0);
    assign enq   = bus.iw_ia_valid && ready && !bus.iw_flush;
    assign deq   = valid && !bus.iw_stall && !bus.iw_flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (bus.iw_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (bus.iw_ia_valid && !ready) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    stg1if_pbuf_mem #(
        .P_DEPTH (P_DEPTH),
        .P_W     (EW)
    ) u_mem (
        .iw_clk   (iw_clk),
        .iw_rst   (iw_rst),
        .iw_we    (enq),
        .iw_waddr (wr_ptr_q),
        .iw_wdata ({bus.iw_pc, bus.iw_mem_data}),
        .iw_raddr (rd_ptr_q),
        .ow_rdata (head)
    );

    // Stale storage survives a flush, so the head is masked when empty.
    assign bus.ow_ready = ready;
    assign bus.ow_valid = valid;
    assign bus.ow_pc    = valid ? head[EW-1:P_DATA_W] : '0;
    assign bus.ow_instr = valid ? head[P_DATA_W-1:0] : '0;
    assign bus.ow_count = count_q;
    assign bus.ow_ovf   = ovf_q;
endmodule

// File: tb/tb_stg1if_pbuf.sv
// Directed bench for stg1if_pbuf with hand-computed expectations.
// Inputs change and outputs are checked on the falling clock edge.
module tb_stg1if_pbuf;
    logic iw_clk = 1'b0;
    logic iw_rst = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    always #5 iw_clk = ~iw_clk;

    stg1if_pbuf_if #(.P_DATA_W(32), .P_ADDR_W(32), .P_DEPTH(4)) bus ();

    stg1if_pbuf #(.P_DATA_W(32), .P_ADDR_W(32), .P_DEPTH(4)) dut (
        .iw_clk (iw_clk),
        .iw_rst (iw_rst),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic s, input logic f);
        bus.iw_ia_valid = v;
        bus.iw_pc       = pc;
        bus.iw_mem_data = pc + 32'hA0;
        bus.iw_stall    = s;
        bus.iw_flush    = f;
    endtask

    task automatic cyc();
        @(negedge iw_clk);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_cnt"}, 32'(bus.ow_count), 0);
        chk({tag, "_vld"}, 32'(bus.ow_valid), 0);
        chk({tag, "_pc"}, bus.ow_pc, 0);
        chk({tag, "_ins"}, bus.ow_instr, 0);
    endtask

    initial begin
        drive(0, 0, 0, 0);
        #12;
        chk_empty("rst");
        chk("rst_rdy", 32'(bus.ow_ready), 1);
        chk("rst_ovf", 32'(bus.ow_ovf), 0);
        cyc();
        iw_rst = 1'b0;

        // single word, no stall
        drive(1, 32'h10, 0, 0);
        bus.iw_mem_data = 32'hA1;
        cyc();
        drive(0, 0, 0, 0);
        chk("one_vld", 32'(bus.ow_valid), 1);
        chk("one_pc", bus.ow_pc, 32'h10);
        chk("one_ins", bus.ow_instr, 32'hA1);
        cyc();
        chk_empty("one_after");

        // fill under stall, overflow on 5th
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'(i), 1, 0);
            cyc();
            chk("fill_cnt", 32'(bus.ow_count), (i < 4) ? 32'(i + 1) : 4);
            chk("fill_head", bus.ow_pc, 0);
            if (i == 3) chk("fill_rdy", 32'(bus.ow_ready), 0);
            chk("fill_ovf", 32'(bus.ow_ovf), (i == 4) ? 1 : 0);
        end
        drive(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", bus.ow_pc, 32'(k));
            chk("drain_ins", bus.ow_instr, 32'(k) + 32'hA0);
            cyc();
        end
        chk_empty("drain_end");
        chk("ovf_sticky", 32'(bus.ow_ovf), 1);
        drive(0, 0, 0, 1);
        cyc();
        chk("ovf_clr", 32'(bus.ow_ovf), 0);

        // stall-on-empty has no effect
        drive(0, 0, 1, 0);
        cyc();
        chk_empty("stall_empty");

        // steady state at count 2, pointers wrap
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h20 + 32'(i), 1, 0);
            cyc();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h22 + 32'(i), 0, 0);
            chk("ss_cnt", 32'(bus.ow_count), 2);
            chk("ss_pc", bus.ow_pc, 32'h20 + 32'(i));
            cyc();
        end
        drive(0, 0, 0, 0);
        chk("ss_ovf", 32'(bus.ow_ovf), 0);
        chk("ss_tail0", bus.ow_pc, 32'h2A);
        cyc();
        chk("ss_tail1", bus.ow_pc, 32'h2B);
        cyc();
        chk_empty("ss_end");

        // flush with incoming word at count 3
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h30 + 32'(i), 1, 0);
            cyc();
        end
        chk("fl_pre", 32'(bus.ow_count), 3);
        drive(1, 32'h33, 1, 1);
        cyc();
        chk_empty("fl");
        chk("fl_ovf", 32'(bus.ow_ovf), 0);
        drive(0, 0, 0, 0);
        cyc();
        chk_empty("fl_after");

        // full, no stall, extra word: drain one, drop word, ovf
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h50 + 32'(i), 1, 0);
            cyc();
        end
        drive(1, 32'h54, 0, 0);
        cyc();
        drive(0, 0, 0, 0);
        chk("fd_cnt", 32'(bus.ow_count), 3);
        chk("fd_ovf", 32'(bus.ow_ovf), 1);
        for (int k = 1; k < 4; k++) begin
            chk("fd_pc", bus.ow_pc, 32'h50 + 32'(k));
            cyc();
        end
        chk_empty("fd_end");
        drive(0, 0, 0, 1);
        cyc();

        // async reset mid-cycle with count 3
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h60 + 32'(i), 1, 0);
            cyc();
        end
        drive(0, 0, 1, 0);
        @(posedge iw_clk);
        #3;
        iw_rst = 1'b1;
        #1;
        chk_empty("arst");
        chk("arst_rdy", 32'(bus.ow_ready), 1);
        cyc();
        iw_rst = 1'b0;
        drive(1, 32'h40, 0, 0);
        cyc();
        drive(0, 0, 0, 0);
        chk("post_vld", 32'(bus.ow_valid), 1);
        chk("post_pc", bus.ow_pc, 32'h40);
        chk("post_cnt", 32'(bus.ow_count), 1);
        cyc();
        chk_empty("post_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stg1if_pbuf.md
STG1IF_PBUF -- requirements
Module: stg1if_pbuf

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  P_DATA_W, `SIZE_DATA, instruction word width
  P_ADDR_W, `SIZE_ADDR, PC width
  P_DEPTH, 4, prefetch entries; power of 2, >=2
REQ-002 Ports SHALL be, one per line (name  direction  width  meaning):
  iw_clk  in  1  clock, rising edge
  iw_rst  in  1  reset, asynchronous, active-high
  iw_ia_valid  in  1  fetch word valid this cycle
  iw_pc  in  P_ADDR_W  PC of fetched word
  iw_mem_data  in  P_DATA_W  fetched instruction
  iw_stall  in  1  decode not accepting this cycle
  iw_flush  in  1  discard all buffered and incoming words
  ow_ready  out  1  buffer can accept (count < P_DEPTH)
  ow_valid  out  1  head entry valid
  ow_pc  out  P_ADDR_W  head PC, 0 when empty
  ow_instr  out  P_DATA_W  head instruction, 0 (NOP) when empty
  ow_count  out  $clog2(P_DEPTH+1)  occupied entries
  ow_ovf  out  1  sticky: valid word arrived while not ready

Function
REQ-003 Enqueue SHALL occur on a rising edge iff iw_ia_valid && ow_ready && !iw_flush; entry {iw_pc, iw_mem_data} written at write pointer.
REQ-004 Dequeue SHALL occur on a rising edge iff ow_valid && !iw_stall && !iw_flush; read pointer advances.
REQ-005 ow_valid SHALL equal (ow_count != 0); ow_pc/ow_instr SHALL show head entry when valid, all-zero otherwise.
REQ-006 Latency: word enqueued into an empty buffer SHALL appear on outputs the cycle after the enqueue edge.
REQ-007 Pointers SHALL be $clog2(P_DEPTH) bits and wrap modulo P_DEPTH.
REQ-008 Simultaneous enqueue and dequeue SHALL leave ow_count unchanged; enqueue alone +1, dequeue alone -1.
REQ-009 ow_ready SHALL derive from registered count only; full with simultaneous dequeue SHALL NOT accept (word ignored, ow_ovf set).
REQ-010 iw_ia_valid && !ow_ready && !iw_flush SHALL set ow_ovf next edge; incoming word discarded, storage unchanged.
REQ-011 iw_flush SHALL have priority over enqueue/dequeue: next edge count=0, pointers=0, ow_ovf=0, outputs zero; same-cycle fetch word dropped.
REQ-012 Storage contents need not be cleared by flush; outputs SHALL still be zero while empty.
REQ-013 iw_stall with empty buffer SHALL have no effect.

Reset
REQ-014 iw_rst assertion SHALL immediately force count=0, pointers=0, ow_ovf=0, ow_valid=0, ow_pc=0, ow_instr=0, ow_ready=1, independent of iw_clk.
REQ-015 Reset mid-operation SHALL discard all entries; first enqueue after deassertion behaves as REQ-006.
REQ-016 All state SHALL sit in one asynchronous-reset process family; no logic SHALL sample inputs while iw_rst is high.

Structure
REQ-017 SIZE_DATA/SIZE_ADDR/HBIT_* SHALL come from shared sizes.vh; no new package constants beyond these.
REQ-018 Storage SHALL be a sub-module stg1if_pbuf_mem (P_DEPTH x (P_ADDR_W+P_DATA_W) register array, 1 write port, async read); control, pointers, count in stg1if_pbuf.

Verification
REQ-019 Reset then pc=0x10,instr=0xA1 valid 1 cycle, stall=0 -> next cycle ow_valid=1, ow_pc=0x10, ow_instr=0xA1; cycle after, ow_valid=0, outputs 0.
REQ-020 stall=1, 5 valid words pc=0..4 (P_DEPTH=4) -> count 1,2,3,4,4; ow_ready=0 after 4th; ow_ovf=1 after 5th; release stall -> pc 0,1,2,3 in order.
REQ-021 count=2, valid word with stall=0 each cycle for 10 cycles -> count stays 2, PCs output in order, pointers wrap, no ovf.
REQ-022 count=3 plus valid word and iw_flush same cycle -> next cycle count=0, ow_valid=0, ow_pc=0, ow_ovf=0; flushed word never appears.
REQ-023 Assert iw_rst asynchronously mid-cycle with count=3 -> outputs zero before next edge; after release, enqueue pc=0x40 appears one cycle later.
REQ-024 Full buffer, stall=0, valid word -> dequeue occurs, count 4->3, word dropped, ow_ovf=1.
